// File: rtl/pong_speed_ctrl.sv
// Game-tick rate controller: start/speed-up/hold sequencing over a shared 32-bit period counter.
// Optional `SPEED_OVERRIDE_EN adds ovr_en/ovr_div to force the divide value at period boundaries.
module pong_speed_ctrl #(
    parameter logic [31:0] BASE_DIV   = 32'd4999,
    parameter logic [31:0] STEP_DIV   = 32'd500,
    parameter logic [31:0] MIN_DIV    = 32'd999,
    parameter logic [3:0]  MAX_LEVEL  = 4'd8,
    parameter logic [7:0]  HOLD_TICKS = 8'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hit,
    input  logic        miss,
`ifdef SPEED_OVERRIDE_EN
    input  logic        ovr_en,
    input  logic [31:0] ovr_div,
`endif
    output logic        tick,
    output logic [31:0] div_value,
    output logic [3:0]  level,
    output logic        running
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt;
    logic [3:0]  pend_level;
    logic [3:0]  pend_hit;
    logic [31:0] pend_div;
    logic [7:0]  hold_cnt;
    logic        wrap;

    // Clamp to MIN_DIV before subtracting so a deep level can never underflow the divide value.
    function automatic logic [31:0] div_for_level(input logic [3:0] lvl);
        logic [31:0] drop;
        drop = 32'(lvl) * STEP_DIV;
        if (drop > BASE_DIV - MIN_DIV)
            return MIN_DIV;
        return BASE_DIV - drop;
    endfunction

    assign wrap = (cnt == div_value);

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        pend_hit = pend_level;
        if (state == RUN && hit && !miss)
            pend_hit = (pend_level >= MAX_LEVEL) ? MAX_LEVEL : pend_level + 4'd1;
    end

`ifdef SPEED_OVERRIDE_EN
    always_comb begin
        pend_div = div_for_level(pend_hit);
        if (ovr_en)
            pend_div = (ovr_div < MIN_DIV) ? MIN_DIV : ovr_div;
    end
`else
    assign pend_div = div_for_level(pend_hit);
`endif

    // NOTE: all state is sequential and uses non-blocking assignments with the async reset in the sensitivity list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (miss) state_nxt = HOLD;
            HOLD:    if (wrap && hold_cnt == HOLD_TICKS - 8'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tick    = (state == RUN) && wrap;
        running = (state == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            div_value  <= BASE_DIV;
            level      <= '0;
            pend_level <= '0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        div_value  <= BASE_DIV;
                        level      <= '0;
                        pend_level <= '0;
                    end
                end
                RUN: begin
                    if (miss) begin
                        cnt        <= '0;
                        div_value  <= BASE_DIV;
                        level      <= '0;
                        pend_level <= '0;
                        hold_cnt   <= '0;
                    end else begin
                        pend_level <= pend_hit;
                        // New rate lands only at the period boundary so no period is cut short.
                        if (wrap) begin
                            cnt       <= '0;
                            div_value <= pend_div;
                            level     <= pend_hit;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                end
                HOLD: begin
                    if (wrap) begin
                        cnt      <= '0;
                        hold_cnt <= hold_cnt + 8'd1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_speed_ctrl.sv
// Bench for pong_speed_ctrl: table of speed-up periods, directed hold/start/reset sequences,
// then randomized pulses against an arithmetic reference model.
module tb_pong_speed_ctrl;

    localparam int BASE = 4999;
    localparam int STEP = 500;
    localparam int MIN  = 999;
    localparam int MAXL = 8;
    localparam int HOLDN = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        hit = 1'b0;
    logic        miss = 1'b0;
    logic        tick;
    logic [31:0] div_value;
    logic [3:0]  level;
    logic        running;
`ifdef SPEED_OVERRIDE_EN
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_div = 32'd0;
`endif

    int test_cnt = 0;
    int fail_cnt = 0;

    pong_speed_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .hit       (hit),
        .miss      (miss),
`ifdef SPEED_OVERRIDE_EN
        .ovr_en    (ovr_en),
        .ovr_div   (ovr_div),
`endif
        .tick      (tick),
        .div_value (div_value),
        .level     (level),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs set here are sampled by the next posedge; returns at the following negedge.
    task automatic pulse(input logic s, input logic h, input logic m);
        start = s; hit = h; miss = m;
        @(negedge clk);
        start = 1'b0; hit = 1'b0; miss = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < budget);
        check("tick_seen", {31'd0, tick}, 32'd1);
    endtask

    // Reference model: period length and speed level computed directly from the rules.
    int m_mode;   // 0 idle, 1 run, 2 hold
    int m_phase, m_div, m_lvl, m_pend, m_holds;

    function automatic int exp_div(input int lvl);
        int d;
        d = BASE - lvl * STEP;
        return (d < MIN) ? MIN : d;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_div = BASE; m_lvl = 0; m_pend = 0; m_holds = 0;
    endtask

    task automatic model_step(input bit s, input bit h, input bit m);
        bit period_end;
        period_end = (m_phase == m_div);
        case (m_mode)
            0: if (s) begin m_mode = 1; m_phase = 0; m_div = BASE; end
            1: begin
                if (m) begin
                    m_mode = 2; m_phase = 0; m_div = BASE; m_lvl = 0; m_pend = 0; m_holds = 0;
                end else begin
                    if (h) m_pend = (m_pend + 1 > MAXL) ? MAXL : m_pend + 1;
                    if (period_end) begin
                        m_phase = 0; m_lvl = m_pend; m_div = exp_div(m_pend);
                    end else m_phase++;
                end
            end
            default: begin
                if (period_end) begin
                    m_phase = 0;
                    m_holds++;
                    if (m_holds == HOLDN) m_mode = 0;
                end else m_phase++;
            end
        endcase
    endtask

    typedef struct {
        int offset;
        int nhits;
        bit hit_on_tick;
        int exp_wait;
        int exp_level;
        int exp_div;
    } row_t;

    row_t rows[5];

    initial begin
        int n, k;
        bit bad;
        logic [31:0] exp_o, act_o;

        rows[0] = '{1000, 1, 1'b0, 4999, 1, 4499};
        rows[1] = '{10,   2, 1'b1, 4499, 4, 2999};
        rows[2] = '{0,    3, 1'b0, 2999, 7, 1499};
        rows[3] = '{100,  3, 1'b1, 1499, 8, 999};
        rows[4] = '{5,    1, 1'b0, 999,  8, 999};

        // Reset values and first periods after start
        wait_cycles(3);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_div", div_value, BASE);
        reset = 1'b0;
        wait_cycles(2);
        pulse(1'b0, 1'b1, 1'b1);
        check("idle_ignores_hit_miss", {31'd0, running}, 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check("start_running", {31'd0, running}, 32'd1);
        wait_tick(6000, n);
        check("first_tick_delay", n, 32'd4999);
        check("run_div", div_value, BASE);
        wait_tick(6000, n);
        check("period_base", n, 32'd5000);
        @(negedge clk);

        // Speed-up table: hits within a period, some landing on the tick cycle itself
        foreach (rows[i]) begin
            wait_cycles(rows[i].offset);
            for (int h = 0; h < rows[i].nhits; h++) pulse(1'b0, 1'b1, 1'b0);
            wait_tick(6000, k);
            check($sformatf("row%0d_period", i), rows[i].offset + rows[i].nhits + k, rows[i].exp_wait);
            if (rows[i].hit_on_tick) pulse(1'b0, 1'b1, 1'b0);
            else @(negedge clk);
            check($sformatf("row%0d_level", i), {28'd0, level}, rows[i].exp_level);
            check($sformatf("row%0d_div", i), div_value, rows[i].exp_div);
        end

        // Hit+miss on a tick cycle: tick kept, then silent hold of HOLDN base periods
        wait_tick(2000, n);
        check("floor_period", n, 32'd999);
        hit = 1'b1; miss = 1'b1;
        check("miss_tick_kept", {31'd0, tick}, 32'd1);
        @(negedge clk);
        hit = 1'b0; miss = 1'b0;
        check("hold_level", {28'd0, level}, 32'd0);
        check("hold_div", div_value, BASE);
        bad = 1'b0;
        for (int c = 1; c <= 15000; c++) begin
            @(negedge clk);
            if (tick || running) bad = 1'b1;
            start = (c == 7000 || c == 14999 || c == 15000);
        end
        check("hold_silent", {31'd0, bad}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("idle_then_start", {31'd0, running}, 32'd1);

        // start during RUN must not disturb the tick phase
        wait_cycles(2000);
        pulse(1'b1, 1'b0, 1'b0);
        wait_tick(6000, k);
        check("start_in_run_ignored", 2001 + k, 32'd4999);

        // Reach level 5, then assert reset between clock edges
        @(negedge clk);
        wait_cycles(10);
        for (int h = 0; h < 5; h++) pulse(1'b0, 1'b1, 1'b0);
        wait_tick(6000, k);
        @(negedge clk);
        check("lvl5_level", {28'd0, level}, 32'd5);
        check("lvl5_div", div_value, 32'd2499);
        wait_cycles(700);
        #2 reset = 1'b1;
        #1;
        check("async_rst_level", {28'd0, level}, 32'd0);
        check("async_rst_div", div_value, BASE);
        check("async_rst_running", {31'd0, running}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        wait_tick(6000, n);
        check("restart_first_tick", n, 32'd4999);
        check("restart_div", div_value, BASE);

        // Randomized pulses against the reference model
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        begin
            int rfails;
            bit s, h, m;
            rfails = fail_cnt;
            for (int c = 0; c < 20000; c++) begin
                exp_o = {(m_mode == 1 && m_phase == m_div) ? 1'b1 : 1'b0,
                         (m_mode == 1) ? 1'b1 : 1'b0, 4'(m_lvl), 26'(m_div)};
                act_o = {tick, running, level, div_value[25:0]};
                check("random_outputs", act_o, exp_o);
                if (fail_cnt - rfails > 10) break;
                s = ($urandom_range(0, 99) < 3);
                h = ($urandom_range(0, 149) == 0) || ($urandom_range(0, 1) == 0 && m_mode == 1 && m_phase == m_div);
                m = ($urandom_range(0, 9999) == 0) || (c == 4000);
                start = s; hit = h; miss = m;
                model_step(s, h, m);
                @(negedge clk);
            end
            start = 1'b0; hit = 1'b0; miss = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
